// File: rtl/ex_muldiv.sv
// ============================================================================
// Module  : ex_muldiv
// Purpose : Execute-stage iterative multiply/divide unit with HI/LO registers.
//           Optional FAST_MUL_EN: single-cycle MULT/MULTU, divide unchanged.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  localparam logic [4:0] C_MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] C_MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] C_DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] C_DIVU_CONTROL  = 5'b10011;
  localparam logic [4:0] C_MTHI_CONTROL  = 5'b10100;
  localparam logic [4:0] C_MTLO_CONTROL  = 5'b10101;
  localparam logic [5:0] C_LAST_ITER     = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [5:0]         r_cnt;
  logic               r_div;
  logic               r_sgn;
  logic               r_sa;
  logic               r_sb;
  logic               r_dz;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle;
  logic               w_take;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed_op;
  logic               w_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  assign w_idle      = (r_state == S_IDLE);
  assign w_take      = valid_i & ~flush_i;
  assign w_is_mul    = w_take & ((alucontrol == C_MULT_CONTROL) | (alucontrol == C_MULTU_CONTROL));
  assign w_is_div    = w_take & ((alucontrol == C_DIV_CONTROL)  | (alucontrol == C_DIVU_CONTROL));
  assign w_signed_op = (alucontrol == C_MULT_CONTROL) | (alucontrol == C_DIV_CONTROL);

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_a;
  logic [2*WIDTH-1:0] w_fast_b;
  logic [2*WIDTH-1:0] w_fast_prod;

  // Sign-extend to 64 bits; the truncated product is correct for both signednesses.
  assign w_fast_a    = {{WIDTH{w_signed_op & srca[WIDTH-1]}}, srca};
  assign w_fast_b    = {{WIDTH{w_signed_op & srcb[WIDTH-1]}}, srcb};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_start     = w_idle & w_is_div;
`else
  assign w_start     = w_idle & (w_is_mul | w_is_div);
`endif

  assign w_abs_a = (w_signed_op & srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
  assign w_abs_b = (w_signed_op & srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

  // Multiply: accumulator upper half gathers partial sums, lower half shifts out the multiplier.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: dividend shifts out of r_acc[WIDTH-1:0] while quotient bits shift in.
  assign w_trial   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_diff    = {1'b0, w_trial} - {2'b00, r_b};
  assign w_ge      = ~w_diff[WIDTH+1];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH:0] : w_trial;
  assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

  assign w_prod_fix = (r_sgn & (r_sa ^ r_sb)) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = (r_sgn & ~r_dz & (r_sa ^ r_sb)) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = (r_sgn & ~r_dz & r_sa) ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = w_start | (r_state == S_ITER);
    busy_o      = ~w_idle;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_ITER;
        S_ITER:  if (r_cnt == C_LAST_ITER) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_sgn <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_dz  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_rem <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_div <= w_is_div;
      r_sgn <= w_signed_op;
      r_sa  <= w_signed_op & srca[WIDTH-1];
      r_sb  <= w_signed_op & srcb[WIDTH-1];
      r_dz  <= (srcb == '0);
      r_a   <= w_abs_a;
      r_b   <= w_abs_b;
      r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
      r_rem <= '0;
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_div) begin
        r_rem <= w_rem_nxt;
        r_acc <= {{WIDTH{1'b0}}, w_quo_nxt};
      end else begin
        r_acc <= w_mul_nxt;
      end
    end
  end

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if ((r_state == S_FIX) && !flush_i) begin
      w_hi_nxt = r_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_nxt = r_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
    end else if (w_idle && w_take) begin
      if (alucontrol == C_MTHI_CONTROL) w_hi_nxt = srca;
      if (alucontrol == C_MTLO_CONTROL) w_lo_nxt = srca;
`ifdef FAST_MUL_EN
      if (w_is_mul) begin
        w_hi_nxt = w_fast_prod[2*WIDTH-1:WIDTH];
        w_lo_nxt = w_fast_prod[WIDTH-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// Module  : tb_ex_muldiv
// Purpose : Directed table-driven bench for ex_muldiv plus flush/reset/MT sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv;

  localparam logic [4:0] MULT  = 5'b10000;
  localparam logic [4:0] MULTU = 5'b10001;
  localparam logic [4:0] DIV   = 5'b10010;
  localparam logic [4:0] DIVU  = 5'b10011;
  localparam logic [4:0] MTHI  = 5'b10100;
  localparam logic [4:0] MTLO  = 5'b10101;
  localparam logic [4:0] OTHER = 5'b00010;
`ifdef FAST_MUL_EN
  localparam int MUL_ST = 0;
`else
  localparam int MUL_ST = 33;
`endif
  localparam int DIV_ST = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic [4:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid_i    (valid_i),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    int          st;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];
  int   errors = 0;
  int   checks = 0;
  int   nst;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op from edge+1, count stall cycles, return one cycle after it leaves EX.
  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    valid_i = 1'b1; alucontrol = c; srca = a; srcb = b; n = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (stall_o) n++;
      else break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_i = 1'b0; alucontrol = 5'd0;
  endtask

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        MUL_ST, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{DIVU,  32'd100,      32'd7,        DIV_ST, 32'd2,        32'd14};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        DIV_ST, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{DIV,   32'd5,        32'd0,        DIV_ST, 32'd5,        32'hFFFFFFFF};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, DIV_ST, 32'd0,        32'h80000000};
    vecs[5]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_ST, 32'hFFFFFFFE, 32'h00000001};
    vecs[6]  = '{MULT,  32'h80000000, 32'h80000000, MUL_ST, 32'h40000000, 32'h00000000};
    vecs[7]  = '{DIVU,  32'hFFFFFFFF, 32'h10,       DIV_ST, 32'hF,        32'h0FFFFFFF};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, DIV_ST, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{MTHI,  32'h12345678, 32'd0,        0,      32'h12345678, 32'hFFFFFFFD};
    vecs[10] = '{MTLO,  32'h0000CAFE, 32'd0,        0,      32'h12345678, 32'h0000CAFE};
    vecs[11] = '{OTHER, 32'h55555555, 32'd3,        0,      32'h12345678, 32'h0000CAFE};
    vecs[12] = '{MULT,  32'd7,        32'hFFFFFFFF, MUL_ST, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[13] = '{DIVU,  32'd9,        32'd0,        DIV_ST, 32'd9,        32'hFFFFFFFF};

    resetn = 1'b1; valid_i = 1'b0; alucontrol = 5'd0; srca = '0; srcb = '0; flush_i = 1'b0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_hi", hi_o, 32'd0);
    check32("reset_lo", lo_o, 32'd0);
    check32("reset_busy", {31'd0, busy_o}, 32'd0);
    check32("reset_stall", {31'd0, stall_o}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, nst);
      check32($sformatf("v%0d_stall_cycles", i), nst, vecs[i].st);
      check32($sformatf("v%0d_hi", i), hi_o, vecs[i].hi);
      check32($sformatf("v%0d_lo", i), lo_o, vecs[i].lo);
      check32($sformatf("v%0d_busy", i), {31'd0, busy_o}, 32'd0);
    end

    // Flush mid-divide leaves HI untouched and returns to IDLE next cycle.
    issue(MTHI, 32'hAAAA, 32'd0, nst);
    valid_i = 1'b1; alucontrol = DIVU; srca = 32'd100; srcb = 32'd7;
    #1 check32("flush_start_stall", {31'd0, stall_o}, 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    check32("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0; alucontrol = 5'd0;
    #1;
    check32("flush_busy", {31'd0, busy_o}, 32'd0);
    check32("flush_stall", {31'd0, stall_o}, 32'd0);
    check32("flush_hi", hi_o, 32'hAAAA);
    repeat (40) @(posedge clk);
    #1 check32("flush_hi_later", hi_o, 32'hAAAA);

    // Asynchronous reset mid-divide clears everything immediately.
    issue(MTHI, 32'hAAAA, 32'd0, nst);
    valid_i = 1'b1; alucontrol = DIVU; srca = 32'd100; srcb = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    resetn = 1'b0; valid_i = 1'b0; alucontrol = 5'd0;
    #1;
    check32("rst_busy", {31'd0, busy_o}, 32'd0);
    check32("rst_stall", {31'd0, stall_o}, 32'd0);
    check32("rst_hi", hi_o, 32'd0);
    check32("rst_lo", lo_o, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // MTLO followed immediately by MULTU.
    valid_i = 1'b1; alucontrol = MTLO; srca = 32'h1234; srcb = 32'd0;
    #1 check32("mtlo_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    check32("mtlo_lo", lo_o, 32'h1234);
    issue(MULTU, 32'd3, 32'd4, nst);
    check32("multu_stall_cycles", nst, MUL_ST);
    check32("multu_hi", hi_o, 32'd0);
    check32("multu_lo", lo_o, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
